// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline types for the ID/EX slice: decoder control bundle, ALUOp codes, x0 index.
package ca_pipe_pkg;

  typedef struct packed {
    logic       Branch;
    logic       MemtoReg;
    logic [1:0] ALUOp;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A live load that writes a register; the only producer a consumer in ID must wait for.
  function automatic logic is_reg_load(input ctrl_t c);
    return c.MemtoReg & c.RegWrite;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bus: decoder/regfile fields in, registered EX fields out, plus stall/flush/hold.
// Counter signals exist only when ID_EX_PERF_CNT_EN is defined.
interface id_ex_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);

  logic            valid_i;
  logic            hold_i;
  logic            flush_i;
  logic            Branch_i;
  logic            MemtoReg_i;
  logic [1:0]      ALUOp_i;
  logic            MemWrite_i;
  logic            ALUSrc_i;
  logic            RegWrite_i;
  logic [XLEN-1:0] RS1data_i;
  logic [XLEN-1:0] RS2data_i;
  logic [XLEN-1:0] Imm_i;
  logic [9:0]      funct_i;
  logic [4:0]      RS1addr_i;
  logic [4:0]      RS2addr_i;
  logic [4:0]      RDaddr_i;

  logic            stall_o;
  logic            valid_o;
  logic            Branch_o;
  logic            MemtoReg_o;
  logic [1:0]      ALUOp_o;
  logic            MemWrite_o;
  logic            ALUSrc_o;
  logic            RegWrite_o;
  logic [XLEN-1:0] RS1data_o;
  logic [XLEN-1:0] RS2data_o;
  logic [XLEN-1:0] Imm_o;
  logic [9:0]      funct_o;
  logic [4:0]      RS1addr_o;
  logic [4:0]      RS2addr_o;
  logic [4:0]      RDaddr_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
`endif

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("id_ex_if: CNT_W must be at least 1");
  end

  modport slave (
    input  valid_i, hold_i, flush_i,
    input  Branch_i, MemtoReg_i, ALUOp_i, MemWrite_i, ALUSrc_i, RegWrite_i,
    input  RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
    output stall_o, valid_o,
    output Branch_o, MemtoReg_o, ALUOp_o, MemWrite_o, ALUSrc_o, RegWrite_o,
    output RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o
`ifdef ID_EX_PERF_CNT_EN
    , output stall_cnt_o, flush_cnt_o
`endif
  );

  modport master (
    output valid_i, hold_i, flush_i,
    output Branch_i, MemtoReg_i, ALUOp_i, MemWrite_i, ALUSrc_i, RegWrite_i,
    output RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
    input  stall_o, valid_o,
    input  Branch_o, MemtoReg_o, ALUOp_o, MemWrite_o, ALUSrc_o, RegWrite_o,
    input  RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o
`ifdef ID_EX_PERF_CNT_EN
    , input stall_cnt_o, flush_cnt_o
`endif
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use comparator: the EX-stage load's rd against both ID source indices.
module hazard_detect
  import ca_pipe_pkg::*;
(
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_ex_valid,
  input  ctrl_t      i_ex_ctrl,
  input  logic [4:0] i_ex_rd,
  output logic       o_hazard
);

  logic w_rd_live;
  logic w_rd_match;

  // rs2 is compared even for I-type; a spurious stall there is harmless.
  assign w_rd_live  = i_ex_valid & is_reg_load(i_ex_ctrl) & (i_ex_rd != REG_X0);
  assign w_rd_match = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
  assign o_hazard   = i_id_valid & w_rd_live & w_rd_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble and branch-flush kill.
// Define ID_EX_PERF_CNT_EN to add stall/flush event counters.
module id_ex_stage
  import ca_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  id_ex_if.slave bus
);

  ctrl_t           r_ctrl;
  logic            r_valid;
  logic [XLEN-1:0] r_rs1data;
  logic [XLEN-1:0] r_rs2data;
  logic [XLEN-1:0] r_imm;
  logic [9:0]      r_funct;
  logic [4:0]      r_rs1addr;
  logic [4:0]      r_rs2addr;
  logic [4:0]      r_rdaddr;

  ctrl_t w_ctrl_in;
  ctrl_t w_ctrl_load;
  logic  w_hazard;
  logic  w_bubble;

  assign w_ctrl_in = '{
    Branch:   bus.Branch_i,
    MemtoReg: bus.MemtoReg_i,
    ALUOp:    bus.ALUOp_i,
    MemWrite: bus.MemWrite_i,
    ALUSrc:   bus.ALUSrc_i,
    RegWrite: bus.RegWrite_i
  };
  assign w_ctrl_load = bus.valid_i ? w_ctrl_in : CTRL_NOP;

  hazard_detect u_hazard (
    .i_id_valid (bus.valid_i),
    .i_id_rs1   (bus.RS1addr_i),
    .i_id_rs2   (bus.RS2addr_i),
    .i_ex_valid (r_valid),
    .i_ex_ctrl  (r_ctrl),
    .i_ex_rd    (r_rdaddr),
    .o_hazard   (w_hazard)
  );

  // A flushed ID instruction is wrong-path, so it must not freeze the front end.
  assign bus.stall_o = w_hazard & ~bus.flush_i & ~rst_i;
  assign w_bubble    = bus.flush_i | w_hazard;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_ctrl    <= CTRL_NOP;
      r_rs1data <= '0;
      r_rs2data <= '0;
      r_imm     <= '0;
      r_funct   <= '0;
      r_rs1addr <= '0;
      r_rs2addr <= '0;
      r_rdaddr  <= '0;
    end else if (!bus.hold_i) begin
      if (w_bubble) begin
        r_valid <= 1'b0;
        r_ctrl  <= CTRL_NOP;
      end else begin
        r_valid <= bus.valid_i;
        r_ctrl  <= w_ctrl_load;
      end
      // Data fields are don't-care under a bubble, so they always follow ID.
      r_rs1data <= bus.RS1data_i;
      r_rs2data <= bus.RS2data_i;
      r_imm     <= bus.Imm_i;
      r_funct   <= bus.funct_i;
      r_rs1addr <= bus.RS1addr_i;
      r_rs2addr <= bus.RS2addr_i;
      r_rdaddr  <= bus.RDaddr_i;
    end
  end

  assign bus.valid_o    = r_valid;
  assign bus.Branch_o   = r_ctrl.Branch;
  assign bus.MemtoReg_o = r_ctrl.MemtoReg;
  assign bus.ALUOp_o    = r_ctrl.ALUOp;
  assign bus.MemWrite_o = r_ctrl.MemWrite;
  assign bus.ALUSrc_o   = r_ctrl.ALUSrc;
  assign bus.RegWrite_o = r_ctrl.RegWrite;
  assign bus.RS1data_o  = r_rs1data;
  assign bus.RS2data_o  = r_rs2data;
  assign bus.Imm_o      = r_imm;
  assign bus.funct_o    = r_funct;
  assign bus.RS1addr_o  = r_rs1addr;
  assign bus.RS2addr_o  = r_rs2addr;
  assign bus.RDaddr_o   = r_rdaddr;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("id_ex_stage: CNT_W must be at least 1");
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!bus.hold_i) begin
      if (w_hazard && !bus.flush_i) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (bus.flush_i && bus.valid_i) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage against an instruction-level reference model.
module tb_id_ex_stage;
  import ca_pipe_pkg::*;

  localparam int XLEN = 32;
`ifdef ID_EX_PERF_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  localparam int unsigned CNT_MASK = (32'd1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  id_ex_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // What EX should be holding, described as an instruction rather than as registers.
  typedef struct {
    bit          live;
    bit          br, ld, mw, as, rw;
    bit [1:0]    op;
    bit [31:0]   d1, d2, imm;
    bit [9:0]    fn;
    bit [4:0]    a1, a2, rd;
    bit          fields_known;
  } ex_instr_t;

  ex_instr_t   m;
  int unsigned m_stalls;
  int unsigned m_flushes;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_txn = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ID instruction must wait if it reads the register an in-flight load is about to produce.
  function automatic bit id_reads_pending_load();
    if (!bus.valid_i || !m.live || !(m.ld && m.rw) || m.rd == 5'd0) return 1'b0;
    return (bus.RS1addr_i == m.rd) || (bus.RS2addr_i == m.rd);
  endfunction

  task automatic put(input bit v, input bit ld, input bit rw, input bit mw,
                     input bit [1:0] op, input bit [4:0] rd, input bit [4:0] a1, input bit [4:0] a2);
    bus.valid_i    = v;
    bus.Branch_i   = (op == ALUOP_BRANCH);
    bus.MemtoReg_i = ld;
    bus.ALUOp_i    = op;
    bus.MemWrite_i = mw;
    bus.ALUSrc_i   = ld | mw;
    bus.RegWrite_i = rw;
    bus.RS1data_i  = $urandom;
    bus.RS2data_i  = $urandom;
    bus.Imm_i      = $urandom;
    bus.funct_i    = 10'($urandom);
    bus.RS1addr_i  = a1;
    bus.RS2addr_i  = a2;
    bus.RDaddr_i   = rd;
  endtask

  // One clock: check stall_o mid-cycle, advance the model at the edge, check EX after it.
  task automatic step(input string tag);
    bit hz;
    #1;
    hz = id_reads_pending_load();
    chk({tag, ":stall_o"}, bus.stall_o, hz && !bus.flush_i && !rst_i);
    @(posedge clk_i);
    if (rst_i) begin
      m = '{default: 0};
      m.fields_known = 1'b1;
      m_stalls  = 0;
      m_flushes = 0;
    end else if (!bus.hold_i) begin
      if (bus.flush_i && bus.valid_i) m_flushes = (m_flushes + 1) & CNT_MASK;
      if (bus.flush_i || hz) begin
        if (!bus.flush_i) m_stalls = (m_stalls + 1) & CNT_MASK;
        m = '{default: 0};
      end else begin
        m.live = bus.valid_i;
        m.br = bus.valid_i & bus.Branch_i;
        m.ld = bus.valid_i & bus.MemtoReg_i;
        m.op = bus.valid_i ? bus.ALUOp_i : 2'b00;
        m.mw = bus.valid_i & bus.MemWrite_i;
        m.as = bus.valid_i & bus.ALUSrc_i;
        m.rw = bus.valid_i & bus.RegWrite_i;
        m.d1 = bus.RS1data_i;
        m.d2 = bus.RS2data_i;
        m.imm = bus.Imm_i;
        m.fn = bus.funct_i;
        m.a1 = bus.RS1addr_i;
        m.a2 = bus.RS2addr_i;
        m.rd = bus.RDaddr_i;
        m.fields_known = bus.valid_i;
      end
    end
    #1;
    chk({tag, ":valid_o"},    bus.valid_o,    m.live);
    chk({tag, ":Branch_o"},   bus.Branch_o,   m.br);
    chk({tag, ":MemtoReg_o"}, bus.MemtoReg_o, m.ld);
    chk({tag, ":ALUOp_o"},    bus.ALUOp_o,    m.op);
    chk({tag, ":MemWrite_o"}, bus.MemWrite_o, m.mw);
    chk({tag, ":ALUSrc_o"},   bus.ALUSrc_o,   m.as);
    chk({tag, ":RegWrite_o"}, bus.RegWrite_o, m.rw);
    if (m.fields_known) begin
      chk({tag, ":RS1data_o"}, bus.RS1data_o, m.d1);
      chk({tag, ":RS2data_o"}, bus.RS2data_o, m.d2);
      chk({tag, ":Imm_o"},     bus.Imm_o,     m.imm);
      chk({tag, ":funct_o"},   bus.funct_o,   m.fn);
      chk({tag, ":RS1addr_o"}, bus.RS1addr_o, m.a1);
      chk({tag, ":RS2addr_o"}, bus.RS2addr_o, m.a2);
      chk({tag, ":RDaddr_o"},  bus.RDaddr_o,  m.rd);
    end
`ifdef ID_EX_PERF_CNT_EN
    chk({tag, ":stall_cnt_o"}, bus.stall_cnt_o, m_stalls);
    chk({tag, ":flush_cnt_o"}, bus.flush_cnt_o, m_flushes);
`endif
    $display("txn %0d %s rst=%0b hold=%0b flush=%0b hz=%0b -> valid_o=%0b rd_o=%0d rw_o=%0b",
             n_txn, tag, rst_i, bus.hold_i, bus.flush_i, hz, bus.valid_o, bus.RDaddr_o, bus.RegWrite_o);
    n_txn++;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step("reset");
    rst_i = 1'b0;
  endtask

  initial begin
    m = '{default: 0};
    m_stalls = 0;
    m_flushes = 0;
    bus.hold_i  = 1'b0;
    bus.flush_i = 1'b0;
    put(1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD, 5'd0, 5'd0, 5'd0);
    do_reset();
    chk("reset:valid_o", bus.valid_o, 1'b0);
    chk("reset:RS1data_o", bus.RS1data_o, 32'd0);

    // 1: reset mid-stream with a hazard present
    put(1'b1, 1'b1, 1'b1, 1'b0, ALUOP_ADD, 5'd5, 5'd2, 5'd0);
    step("t1_lw");
    put(1'b1, 1'b0, 1'b1, 1'b0, ALUOP_RTYPE, 5'd6, 5'd5, 5'd1);
    rst_i = 1'b1;
    #1 chk("t1:stall_o_in_reset", bus.stall_o, 1'b0);
    step("t1_rst");
    rst_i = 1'b0;
    chk("t1:valid_o", bus.valid_o, 1'b0);
    chk("t1:RegWrite_o", bus.RegWrite_o, 1'b0);

    // 2: lw x5 ; add x6,x5,x1
    put(1'b1, 1'b1, 1'b1, 1'b0, ALUOP_ADD, 5'd5, 5'd2, 5'd0);
    step("t2_lw");
    put(1'b1, 1'b0, 1'b1, 1'b0, ALUOP_RTYPE, 5'd6, 5'd5, 5'd1);
    #1 chk("t2:stall_o", bus.stall_o, 1'b1);
    step("t2_bubble");
    chk("t2:bubble_valid_o", bus.valid_o, 1'b0);
    chk("t2:bubble_MemWrite_o", bus.MemWrite_o, 1'b0);
    #1 chk("t2:stall_released", bus.stall_o, 1'b0);
    step("t2_add");
    chk("t2:add_valid_o", bus.valid_o, 1'b1);
    chk("t2:add_RS1addr_o", bus.RS1addr_o, 5'd5);

    // 3: lw x0 ; add x6,x0,x1 must not stall
    put(1'b1, 1'b1, 1'b1, 1'b0, ALUOP_ADD, 5'd0, 5'd2, 5'd0);
    step("t3_lw");
    put(1'b1, 1'b0, 1'b1, 1'b0, ALUOP_RTYPE, 5'd6, 5'd0, 5'd1);
    #1 chk("t3:stall_o", bus.stall_o, 1'b0);
    step("t3_add");
    chk("t3:add_valid_o", bus.valid_o, 1'b1);
    chk("t3:add_RDaddr_o", bus.RDaddr_o, 5'd6);

    // 4: flush kills a valid sub in ID
    do_reset();
    put(1'b1, 1'b0, 1'b1, 1'b0, ALUOP_RTYPE, 5'd7, 5'd3, 5'd4);
    bus.flush_i = 1'b1;
    step("t4_flush");
    bus.flush_i = 1'b0;
    chk("t4:valid_o", bus.valid_o, 1'b0);
    chk("t4:RegWrite_o", bus.RegWrite_o, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
    chk("t4:flush_cnt_o", bus.flush_cnt_o, 4'd1);
`endif

    // 5: hold for 3 cycles over a load-use hazard
    put(1'b1, 1'b1, 1'b1, 1'b0, ALUOP_ADD, 5'd5, 5'd2, 5'd0);
    step("t5_lw");
    put(1'b1, 1'b0, 1'b1, 1'b0, ALUOP_RTYPE, 5'd6, 5'd5, 5'd1);
    bus.hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5:stall_o_hold", bus.stall_o, 1'b1);
      step("t5_hold");
      chk("t5:frozen_valid_o", bus.valid_o, 1'b1);
      chk("t5:frozen_MemtoReg_o", bus.MemtoReg_o, 1'b1);
      chk("t5:frozen_RDaddr_o", bus.RDaddr_o, 5'd5);
    end
    bus.hold_i = 1'b0;
    #1 chk("t5:stall_o_release", bus.stall_o, 1'b1);
    step("t5_bubble");
    chk("t5:bubble_valid_o", bus.valid_o, 1'b0);
    step("t5_add");
    chk("t5:add_valid_o", bus.valid_o, 1'b1);
    chk("t5:add_RS1addr_o", bus.RS1addr_o, 5'd5);

`ifdef ID_EX_PERF_CNT_EN
    // 6: 17 load-use pairs wrap a 4-bit stall counter to 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      put(1'b1, 1'b1, 1'b1, 1'b0, ALUOP_ADD, 5'd5, 5'd2, 5'd0);
      step("t6_lw");
      put(1'b1, 1'b0, 1'b1, 1'b0, ALUOP_RTYPE, 5'd6, 5'd1, 5'd5);
      step("t6_bubble");
      step("t6_add");
    end
    chk("t6:stall_cnt_o", bus.stall_cnt_o, 4'd1);
`endif

    // Random traffic; small register space and frequent loads keep hazards common.
    for (int i = 0; i < 400; i++) begin
      rst_i       = ($urandom_range(0, 63) == 0);
      bus.hold_i  = ($urandom_range(0, 7) == 0);
      bus.flush_i = ($urandom_range(0, 7) == 0);
      put(($urandom_range(0, 7) != 0), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
          2'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      step("rand");
    end
    rst_i = 1'b0;
    bus.hold_i = 1'b0;
    bus.flush_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
